// File: rtl/d_mem_requester.sv
// Data-memory requester: turns byte-addressed loads/stores into word strobes,
// sub-word stores via read-modify-write. Optional D_MEM_REQ_TIMEOUT_EN adds a wait-state timeout.
module d_mem_requester #(
  parameter int CORE           = 0,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 20,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  input  logic                    req_valid_i,
  input  logic                    req_read_i,
  input  logic                    req_write_i,
  input  logic [2:0]              req_funct3_i,
  input  logic [ADDRESS_BITS-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  output logic                    req_ready_o,
  output logic                    resp_valid_o,
  output logic [DATA_WIDTH-1:0]   resp_data_o,
  output logic                    resp_error_o,
  output logic                    mem_read_o,
  output logic                    mem_write_o,
  output logic [ADDRESS_BITS-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0]   mem_out_data_o,
  input  logic [DATA_WIDTH-1:0]   mem_in_data_i,
  input  logic                    mem_valid_i,
  input  logic                    report_i
);

  typedef enum logic [2:0] {IDLE, LD, LD_WAIT, ST, RMW_RD, RMW_WAIT, RMW_WR, ST_WAIT} state_t;

  state_t                  state_q, state_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [2:0]              f3_q, f3_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_error_q, resp_error_d;
  logic [DATA_WIDTH-1:0]   resp_data_q, resp_data_d;

  logic                    ld_ok, st_ok, misalign, req_err;
  logic [DATA_WIDTH-1:0]   lane, load_ext, merged;

  always_comb begin
    ld_ok    = req_funct3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    st_ok    = req_funct3_i inside {3'b000, 3'b001, 3'b010};
    misalign = (req_funct3_i[1:0] == 2'b10 && req_addr_i[1:0] != 2'b00) ||
               (req_funct3_i[1:0] == 2'b01 && req_addr_i[0]);
    req_err  = (req_read_i == req_write_i) || (req_read_i && !ld_ok) ||
               (req_write_i && !st_ok) || misalign;
  end

  // Byte lane k sits at bits [8k+7:8k]; halfwords are already 2-byte aligned here.
  always_comb begin
    lane = mem_in_data_i >> {addr_q[1:0], 3'b000};
    case (f3_q)
      3'b000:  load_ext = {{(DATA_WIDTH-8){lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {{(DATA_WIDTH-8){1'b0}}, lane[7:0]};
      3'b101:  load_ext = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  always_comb begin
    merged = mem_in_data_i;
    if (f3_q[1:0] == 2'b00) merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    else                    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
  end

`ifdef D_MEM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             unused_cfg;
  assign unused_cfg = report_i ^ (CORE < 0);
`else
  logic             unused_cfg;
  assign unused_cfg = report_i ^ (CORE < 0) ^ (TIMEOUT_CYCLES < 1);
`endif

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    f3_d         = f3_q;
    wdata_d      = wdata_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_data_d  = '0;
    case (state_q)
      IDLE: if (req_valid_i) begin
        addr_d  = req_addr_i;
        f3_d    = req_funct3_i;
        wdata_d = req_wdata_i;
        if (req_err) begin
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else if (req_read_i)            state_d = LD;
        else if (req_funct3_i == 3'b010)    state_d = ST;
        else                                state_d = RMW_RD;
      end
      LD:      state_d = LD_WAIT;
      LD_WAIT: if (mem_valid_i) begin
        resp_valid_d = 1'b1;
        resp_data_d  = load_ext;
        state_d      = IDLE;
      end
      ST:       state_d = ST_WAIT;
      RMW_RD:   state_d = RMW_WAIT;
      RMW_WAIT: if (mem_valid_i) begin
        wdata_d = merged;
        state_d = RMW_WR;
      end
      RMW_WR:  state_d = ST_WAIT;
      ST_WAIT: if (mem_valid_i) begin
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef D_MEM_REQ_TIMEOUT_EN
    // Every wait state is entered from a non-wait state, so clearing outside them restarts the count.
    cnt_d = '0;
    if (state_q inside {LD_WAIT, RMW_WAIT, ST_WAIT}) begin
      cnt_d = cnt_q + 1'b1;
      if (!mem_valid_i && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        resp_valid_d = 1'b1;
        resp_error_d = 1'b1;
        resp_data_d  = '0;
        state_d      = IDLE;
      end
    end
`endif
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      f3_q         <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_data_q  <= '0;
`ifdef D_MEM_REQ_TIMEOUT_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      f3_q         <= f3_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_data_q  <= resp_data_d;
`ifdef D_MEM_REQ_TIMEOUT_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign req_ready_o    = (state_q == IDLE);
  assign resp_valid_o   = resp_valid_q;
  assign resp_error_o   = resp_error_q;
  assign resp_data_o    = resp_data_q;
  assign mem_read_o     = (state_q == LD) || (state_q == RMW_RD);
  assign mem_write_o    = (state_q == ST) || (state_q == RMW_WR);
  assign mem_address_o  = (mem_read_o || mem_write_o) ? {2'b00, addr_q[ADDRESS_BITS-1:2]} : '0;
  assign mem_out_data_o = mem_write_o ? wdata_q : '0;

endmodule
